mdu_seq: RTL and testbench
==========================

# mdu_seq

Iterative multiply/divide sequencer for the RV64M extension, sitting in the execute stage beside the single-cycle ALU. The ALU covers all single-cycle integer ops (ALU, ALU_IMM, BRANCH, JAL/JALR, LUI, AUIPC). This block accepts one MUL/DIV/REM operation at a time and resolves it over multiple cycles using a shift-add multiplier and a restoring divider. The core stalls via `busy_o` until the result is handed back through a valid/ready handshake.

## Interface
- `XLEN`, 64: operand/result width; the iteration counter is clog2(XLEN)+1 bits.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset; one clock, reset is asynchronous and active-low.
- `req_valid_i`  in  1  operation request.
- `req_ready_o`  out  1  high only in IDLE; accept = `req_valid_i & req_ready_o`.
- `op_i`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `word_i`  in  1  *W variant (`op_alu_w` class): operate on bits [31:0], sign-extend the 32-bit result.
- `rs1_rdata_i`, `rs2_rdata_i`  in  XLEN  operands, sampled only on accept.
- `flush_i`  in  1  kill the in-flight op.
- `resp_valid_o`  out  1  result available.
- `resp_ready_i`  in  1  consumer takes the result.
- `res_o`  out  XLEN  result, stable while `resp_valid_o` is high.
- `busy_o`  out  1  high in any state except IDLE.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- **IDLE**
  - On accept, latch op, word, and operands.
  - Go to PREP.
- **PREP**
  - Compute operand signs: signed for MUL/MULH/DIV/REM, rs1 only for MULHSU, none for the U forms.
  - Replace operands with their absolute values.
  - Load counter with N (N = 32 if `word_i`, else XLEN).
  - Divide special cases skip CALC/FIX and go straight to DONE:
    - Divisor zero: quotient all-ones; remainder = dividend (sign-extended for W).
    - Signed overflow (most-negative / -1, at operand width): quotient = dividend; remainder 0.
  - Otherwise go to CALC.
- **CALC**
  - One iteration per cycle; counter decrements; go to FIX when counter reaches 0 after the final iteration.
  - Multiply: 2N-bit accumulator, shift-add.
  - Divide: restoring, 1 quotient bit per cycle.
- **FIX**
  - Negate the product if the operand signs differ.
  - Negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Select the output:
    - MUL: low N bits.
    - MULH*: high N bits.
    - W forms: sign-extend bit 31.
  - Register `res_o`; go to DONE.
- **DONE**
  - `resp_valid_o` high.
  - On `resp_ready_i`, go to IDLE; no same-cycle accept.
- `word_i` with op 1–3 is executed as MULW.
- `flush_i` in any non-IDLE state returns to IDLE on the next edge with no response. A flush in DONE drops the result. `flush_i` in IDLE blocks acceptance that cycle.
- All arithmetic is at 2N+1 bits internally; operands and results never alias across iterations.

## Timing
- Reset values:
  - Outputs: `req_ready_o` 1, `resp_valid_o` 0, `busy_o` 0, `res_o` 0.
  - Internal: state IDLE, counter 0.
- Reset asserted mid-operation aborts immediately; no response is produced after release.
- Latency, with accept at edge k:
  - PREP in cycle k+1.
  - CALC in cycles k+2 .. k+1+N.
  - FIX in cycle k+2+N.
  - `resp_valid_o` from cycle k+3+N: 67 cycles for XLEN=64, 35 for W.
- Special-case divides: `resp_valid_o` from cycle k+2.
- `resp_valid_o` and `res_o` hold until `resp_ready_i`; `req_ready_o` rises the cycle after the handshake.
- Throughput: one operation per (latency + 1) cycles minimum.

## Structure
- `defines.v` additions: `MDU_OP_*` funct3 constants, `MDU_ST_*` state encodings, and `MDU_CNT_WIDTH`.
- Single module; no sub-module.
- The negate/absolute-value logic is a local function used in both PREP and FIX.

## Test plan
- MUL 3 × -5, XLEN=64 → `res_o` 0xFFFF_FFFF_FFFF_FFF1; `resp_valid_o` rises exactly 67 cycles after accept.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × same → 0xFFFF_FFFF_FFFF_FFFE. MULHSU -1 × 2 → 0xFFFF_FFFF_FFFF_FFFF.
- Divide by zero:
  - DIV 7/0 → 0xFFFF_FFFF_FFFF_FFFF; REM 7/0 → 7.
  - Overflow: DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000; REM → 0.
  - All resp at k+2.
- DIVW -7/2 → 0xFFFF_FFFF_FFFF_FFFD; REMW -7/2 → 0xFFFF_FFFF_FFFF_FFFF; resp at 35 cycles. Upper operand bits set to garbage are ignored.
- Flush and reset aborts:
  - `flush_i` on cycle 10 of CALC → no `resp_valid_o`; `req_ready_o` high the next cycle; a following MUL 2×2 returns 4.
  - `rst_n_i` pulse mid-CALC → all outputs at reset values immediately.
- Hold `resp_ready_i` low for 5 cycles in DONE → `res_o` and `resp_valid_o` stable; `req_valid_i` held high is not accepted until the cycle after the handshake.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// Shared types and helpers for the RV64M multiply/divide sequencer.
package mdu_seq_pkg;

   localparam int XLEN  = 64;
   localparam int CNT_W = $clog2(XLEN) + 1;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_CALC = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } mdu_state_e;

   // Two's-complement negate when neg is set; gives |v| for a signed v with neg = sign.
   function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
   endfunction

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

endpackage

// File: rtl/mdu_seq.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per cycle, result returned through a valid/ready handshake.
module mdu_seq
   import mdu_seq_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      op_i,
   input  logic            word_i,
   input  logic [XLEN-1:0] rs1_rdata_i,
   input  logic [XLEN-1:0] rs2_rdata_i,
   input  logic            flush_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [XLEN-1:0] res_o,
   output logic            busy_o
);

   mdu_state_e        state_q;
   mdu_op_e           op_q, op_in;
   logic              word_q, sign_a_q, sign_b_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [XLEN-1:0]   a_q, b_q, quo_q, rem_q, res_q;
   logic [2*XLEN-1:0] acc_q;
   logic              ready_q, valid_q, busy_q;

   logic              signed_a, signed_b, sign_a, sign_b, div_zero, div_ovf;
   logic [XLEN-1:0]   a_ext, b_ext, abs_a, abs_b, min_neg, spec_raw, spec_res;
   logic [XLEN:0]     mul_sum, rem_shift;
   logic [2*XLEN-1:0] acc_nxt;
   logic              div_ge;
   logic [XLEN-1:0]   quo_nxt, rem_nxt;
   logic              prod_neg;
   logic [XLEN-1:0]   pm_lo, pm_hi, prod_lo, prod_hi, fix_raw, fix_res;

   // MULH/MULHSU/MULHU have no W form and are executed as MULW.
   always_comb begin
      op_in = mdu_op_e'(op_i);
      if (word_i && (op_i inside {3'd1, 3'd2, 3'd3})) begin
         op_in = OP_MUL;
      end else begin
         op_in = mdu_op_e'(op_i);
      end
   end

   // Operand conditioning and divide special cases, consumed in PREP.
   always_comb begin
      signed_a = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                 (op_q == OP_DIV) || (op_q == OP_REM);
      signed_b = (op_q == OP_MUL) || (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
      if (word_q) begin
         a_ext   = signed_a ? sext32(a_q[31:0]) : {{(XLEN-32){1'b0}}, a_q[31:0]};
         b_ext   = signed_b ? sext32(b_q[31:0]) : {{(XLEN-32){1'b0}}, b_q[31:0]};
         min_neg = {{(XLEN-31){1'b1}}, {31{1'b0}}};
      end else begin
         a_ext   = a_q;
         b_ext   = b_q;
         min_neg = {1'b1, {(XLEN-1){1'b0}}};
      end
      sign_a   = signed_a & a_ext[XLEN-1];
      sign_b   = signed_b & b_ext[XLEN-1];
      abs_a    = cneg(a_ext, sign_a);
      abs_b    = cneg(b_ext, sign_b);
      div_zero = op_q[2] & (b_ext == {XLEN{1'b0}});
      div_ovf  = op_q[2] & ~op_q[0] & (b_ext == {XLEN{1'b1}}) & (a_ext == min_neg);
      if (div_zero) begin
         spec_raw = op_q[1] ? a_ext : {XLEN{1'b1}};
      end else begin
         spec_raw = op_q[1] ? {XLEN{1'b0}} : a_ext;
      end
      spec_res = word_q ? sext32(spec_raw[31:0]) : spec_raw;
   end

   // One multiplier step and one restoring-divide step; the dividend is left-aligned in quo_q.
   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
      acc_nxt   = {mul_sum, acc_q[XLEN-1:1]};
      rem_shift = {rem_q, quo_q[XLEN-1]};
      div_ge    = (rem_shift >= {1'b0, b_q});
      rem_nxt   = div_ge ? (rem_shift[XLEN-1:0] - b_q) : rem_shift[XLEN-1:0];
      quo_nxt   = {quo_q[XLEN-2:0], div_ge};
   end

   // Sign fix-up and result selection; a W product sits at acc_q[95:32] after 32 steps.
   always_comb begin
      pm_lo    = word_q ? acc_q[XLEN+31:32] : acc_q[XLEN-1:0];
      pm_hi    = word_q ? {XLEN{1'b0}} : acc_q[2*XLEN-1:XLEN];
      prod_neg = sign_a_q ^ sign_b_q;
      prod_lo  = cneg(pm_lo, prod_neg);
      prod_hi  = cneg(pm_hi, prod_neg) - {{(XLEN-1){1'b0}}, prod_neg & (|pm_lo)};
      case (op_q)
         OP_MUL:                       fix_raw = prod_lo;
         OP_MULH, OP_MULHSU, OP_MULHU: fix_raw = prod_hi;
         OP_DIV, OP_DIVU:              fix_raw = cneg(quo_q, sign_a_q ^ sign_b_q);
         OP_REM, OP_REMU:              fix_raw = cneg(rem_q, sign_a_q);
         default:                      fix_raw = prod_lo;
      endcase
      fix_res = word_q ? sext32(fix_raw[31:0]) : fix_raw;
   end

   // Sequencer state, datapath registers and registered handshake outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MUL;
         word_q   <= 1'b0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         cnt_q    <= {CNT_W{1'b0}};
         a_q      <= {XLEN{1'b0}};
         b_q      <= {XLEN{1'b0}};
         quo_q    <= {XLEN{1'b0}};
         rem_q    <= {XLEN{1'b0}};
         res_q    <= {XLEN{1'b0}};
         acc_q    <= {(2*XLEN){1'b0}};
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else if (flush_i && (state_q != ST_IDLE)) begin
         state_q <= ST_IDLE;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid_i && ready_q && !flush_i) begin
                  op_q    <= op_in;
                  word_q  <= word_i;
                  a_q     <= rs1_rdata_i;
                  b_q     <= rs2_rdata_i;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_PREP;
               end
            end
            ST_PREP: begin
               sign_a_q <= sign_a;
               sign_b_q <= sign_b;
               a_q      <= abs_a;
               b_q      <= abs_b;
               cnt_q    <= word_q ? CNT_W'(32) : CNT_W'(XLEN);
               acc_q    <= {{XLEN{1'b0}}, abs_b};
               quo_q    <= word_q ? {abs_a[31:0], {(XLEN-32){1'b0}}} : abs_a;
               rem_q    <= {XLEN{1'b0}};
               if (div_zero || div_ovf) begin
                  res_q   <= spec_res;
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  state_q <= ST_CALC;
               end
            end
            ST_CALC: begin
               cnt_q <= cnt_q - CNT_W'(1);
               if (op_q[2]) begin
                  quo_q <= quo_nxt;
                  rem_q <= rem_nxt;
               end else begin
                  acc_q <= acc_nxt;
               end
               if (cnt_q == CNT_W'(1)) begin
                  state_q <= ST_FIX;
               end
            end
            ST_FIX: begin
               res_q   <= fix_res;
               valid_q <= 1'b1;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               if (resp_ready_i) begin
                  valid_q <= 1'b0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign req_ready_o  = ready_q;
   assign resp_valid_o = valid_q;
   assign busy_o       = busy_q;
   assign res_o        = res_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: directed vectors with hand-computed results and latencies.
module tb_mdu_seq;

   logic        clk = 1'b0;
   logic        rst_n, req_valid, req_ready, word, flush, resp_valid, resp_ready, busy;
   logic [2:0]  op;
   logic [63:0] rs1, rs2, res;

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          acc_cyc;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   rise_cyc = 0;
   logic prev_valid = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mdu_seq dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .op_i         (op),
      .word_i       (word),
      .rs1_rdata_i  (rs1),
      .rs2_rdata_i  (rs2),
      .flush_i      (flush),
      .resp_valid_o (resp_valid),
      .resp_ready_i (resp_ready),
      .res_o        (res),
      .busy_o       (busy)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every response handshake, checks value and latency.
   always @(negedge clk) begin : mon
      exp_t e;
      int   r;
      r = rise_cyc;
      if (resp_valid && !prev_valid) r = cyc;
      rise_cyc   <= r;
      prev_valid <= resp_valid;
      if (resp_valid && resp_ready) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp: got response %h, required none", res);
         end else begin
            e = sb_q.pop_front();
            chk(e.name, res, e.res);
            chk({e.name, "_lat"}, 64'(r - e.acc_cyc), 64'(e.lat));
         end
      end
   end

   task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int lat, input string nm, input bit push);
      int n;
      @(posedge clk); #1;
      op = o; word = w; rs1 = a; rs2 = b; req_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!(req_ready && !flush) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_accept: req_ready_o stayed 0, required 1", nm);
      end else if (push) begin
         sb_q.push_back('{res: exp, lat: lat, acc_cyc: cyc, name: nm});
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || !req_ready) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_drain: %0d responses outstanding, required 0", nm, sb_q.size());
      end
   endtask

   localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

   initial begin : stim
      int n;
      rst_n = 1'b0; req_valid = 1'b0; op = 3'd0; word = 1'b0; rs1 = 64'd0; rs2 = 64'd0;
      flush = 1'b0; resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_res", res, 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      issue(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 67, "mul", 1'b1);
      issue(3'd3, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 67, "mulhu", 1'b1);
      issue(3'd2, 1'b0, ONES, 64'd2, ONES, 67, "mulhsu", 1'b1);
      issue(3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, ONES, 67, "mulh", 1'b1);
      issue(3'd4, 1'b0, 64'd7, 64'd0, ONES, 2, "div_by0", 1'b1);
      issue(3'd6, 1'b0, 64'd7, 64'd0, 64'd7, 2, "rem_by0", 1'b1);
      issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'h8000_0000_0000_0000, 2, "div_ovf", 1'b1);
      issue(3'd6, 1'b0, 64'h8000_0000_0000_0000, ONES, 64'd0, 2, "rem_ovf", 1'b1);
      issue(3'd4, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 35, "divw", 1'b1);
      issue(3'd6, 1'b1, 64'hDEAD_BEEF_FFFF_FFF9, 64'h1234_5678_0000_0002, ONES, 35, "remw", 1'b1);
      issue(3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 67, "div", 1'b1);
      issue(3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 67, "rem", 1'b1);
      issue(3'd1, 1'b1, 64'hABCD_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 35, "mulhw_as_mulw", 1'b1);
      issue(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 2, "divw_ovf", 1'b1);
      issue(3'd5, 1'b1, 64'd5, 64'h0000_0001_0000_0000, ONES, 2, "divuw_by0", 1'b1);
      issue(3'd7, 1'b1, 64'h0000_0000_8000_0001, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001, 2, "remuw_by0", 1'b1);
      drain("vectors");

      // Flush on the 10th CALC cycle: no response, ready again next cycle.
      issue(3'd0, 1'b0, 64'd123, 64'd456, 64'd0, 0, "flushed", 1'b0);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      chk("flush_req_ready", {63'd0, req_ready}, 64'd1);
      chk("flush_busy", {63'd0, busy}, 64'd0);
      repeat (70) @(negedge clk);
      chk("flush_no_resp", {63'd0, resp_valid}, 64'd0);
      issue(3'd0, 1'b0, 64'd2, 64'd2, 64'd4, 67, "mul_after_flush", 1'b1);
      drain("flush");

      // Asynchronous reset in the middle of CALC.
      issue(3'd0, 1'b0, 64'd77, 64'd99, 64'd0, 0, "reset_aborted", 1'b0);
      repeat (20) @(posedge clk);
      @(negedge clk); #2 rst_n = 1'b0; #1;
      chk("midrst_req_ready", {63'd0, req_ready}, 64'd1);
      chk("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_res", res, 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (80) @(negedge clk);
      chk("midrst_no_resp", {63'd0, resp_valid}, 64'd0);

      // Backpressure: result held five cycles; a pending request waits for the handshake.
      @(posedge clk); #1 resp_ready = 1'b0;
      issue(3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 67, "divu_held", 1'b1);
      n = 0;
      while (!resp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         n_cmp++;
         n_bad++;
         $display("FAIL hold_wait: resp_valid_o stayed 0, required 1");
      end
      @(posedge clk); #1;
      op = 3'd7; word = 1'b0; rs1 = 64'd100; rs2 = 64'd7; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_valid", {63'd0, resp_valid}, 64'd1);
         chk("hold_res", res, 64'd14);
         chk("hold_no_accept", {63'd0, req_ready}, 64'd0);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      @(negedge clk);
      chk("handshake_ready", {63'd0, req_ready}, 64'd0);
      @(negedge clk);
      chk("post_handshake_ready", {63'd0, req_ready}, 64'd1);
      sb_q.push_back('{res: 64'd2, lat: 67, acc_cyc: cyc, name: "remu_after_hold"});
      @(posedge clk); #1 req_valid = 1'b0;
      drain("hold");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
